// File: rtl/tm1638_frame_sequencer.sv
// tm1638_frame_sequencer
// Drives the 3-wire serial display link (clk/stb/dio) from the system clock.
// A 16-byte shadow RAM is written by upstream logic. Each refresh frame sends
// three strobe segments: the data command 0x40, then the address 0xC0 with 16
// RAM bytes, then the display control byte. Bits go out LSB first, and the
// display latches each bit on the rising edge of clk.
// Ports:
//   _50MHz_CLK  system clock (rising edge)
//   RST         asynchronous reset, active low
//   wr_en/wr_addr/wr_data  shadow RAM write port, accepted in every state
//   brightness/disp_on     display control, latched at frame start
//   start       one-cycle frame request (queued as pending while busy)
//   busy        high from the first stb-low cycle to the last cycle of the frame
//   frame_done  one-cycle pulse after the final stb rise
//   clk/stb/dio serial link outputs, all idle high
module tm1638_frame_sequencer #(
  parameter int CLK_DIV     = 25,
  parameter int AUTO_PERIOD = 500000
) (
  input  logic       _50MHz_CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] brightness,
  input  logic       disp_on,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic       clk,
  output logic       stb,
  output logic       dio
);

  localparam logic [7:0]    H_LAST    = 8'(CLK_DIV - 1);
  localparam int            AW        = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'((AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0);
  localparam bit            AUTO_EN   = (AUTO_PERIOD > 0);

  typedef enum logic [2:0] {S_IDLE, S_SEG1, S_GAP1, S_SEG2, S_GAP2, S_SEG3, S_DONE} state_t;
  // Phases inside a segment: lead-in with stb low, bit low half, bit high
  // half, tail after the last bit. Gaps reuse LEAD/TAIL as their two halves.
  typedef enum logic [1:0] {PH_LEAD, PH_LOW, PH_HIGH, PH_TAIL} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [4:0]  byte_q, byte_d;
  logic        pending_q, pending_d;
  logic [AW-1:0] auto_q, auto_d;
  logic [2:0]  bright_q;
  logic        disp_q;
  logic [7:0]  ram [16];
  logic [7:0]  tx_byte_q;
  logic [7:0]  tx_next;
  logic [4:0]  load_idx;
  logic [3:0]  ram_idx;
  logic        load_byte, go, half_end, last_byte, auto_hit, seg_act;

  assign auto_hit = AUTO_EN && (auto_q == AUTO_LAST);
  assign ram_idx  = 4'(load_idx - 5'd1);

  // Byte selected for transmission; sampled when its first bit's low phase starts.
  always_comb begin
    tx_next = 8'hFF;
    case (state_q)
      S_SEG1:  tx_next = 8'h40;
      S_SEG2:  tx_next = (load_idx == 5'd0) ? 8'hC0 : ram[ram_idx];
      S_SEG3:  tx_next = {1'b1, 3'b000, disp_q, bright_q};
      default: tx_next = 8'hFF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    hcnt_d    = hcnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    pending_d = pending_q;
    auto_d    = auto_q;
    load_byte = 1'b0;
    load_idx  = 5'd0;
    go        = 1'b0;
    half_end  = (hcnt_q == H_LAST);
    last_byte = (state_q != S_SEG2) || (byte_q == 5'd16);
    case (state_q)
      S_IDLE: begin
        if (start || auto_hit) begin
          go     = 1'b1;
          auto_d = '0;
        end else if (AUTO_EN) begin
          auto_d = auto_q + AW'(1);
        end
      end
      S_SEG1, S_SEG2, S_SEG3: begin
        if (start) pending_d = 1'b1;
        hcnt_d = half_end ? 8'd0 : hcnt_q + 8'd1;
        if (half_end) begin
          case (phase_q)
            PH_LEAD: begin
              phase_d   = PH_LOW;
              load_byte = 1'b1;
              load_idx  = 5'd0;
            end
            PH_LOW: phase_d = PH_HIGH;
            PH_HIGH: begin
              if (bit_q != 3'd7) begin
                bit_d   = bit_q + 3'd1;
                phase_d = PH_LOW;
              end else if (last_byte) begin
                // bit_q stays at 7 so dio holds the last bit through the tail
                phase_d = PH_TAIL;
              end else begin
                bit_d     = 3'd0;
                byte_d    = byte_q + 5'd1;
                load_byte = 1'b1;
                load_idx  = byte_q + 5'd1;
                phase_d   = PH_LOW;
              end
            end
            default: begin
              phase_d = PH_LEAD;
              bit_d   = 3'd0;
              byte_d  = 5'd0;
              case (state_q)
                S_SEG1:  state_d = S_GAP1;
                S_SEG2:  state_d = S_GAP2;
                default: state_d = S_DONE;
              endcase
            end
          endcase
        end
      end
      S_GAP1, S_GAP2: begin
        if (start) pending_d = 1'b1;
        hcnt_d = half_end ? 8'd0 : hcnt_q + 8'd1;
        if (half_end) begin
          if (phase_q == PH_LEAD) begin
            phase_d = PH_TAIL;
          end else begin
            phase_d = PH_LEAD;
            state_d = (state_q == S_GAP1) ? S_SEG2 : S_SEG3;
          end
        end
      end
      default: begin
        // DONE: a queued request chains straight into the next frame
        if (pending_q || start) go = 1'b1;
        else state_d = S_IDLE;
        pending_d = 1'b0;
      end
    endcase
    if (go) begin
      state_d = S_SEG1;
      phase_d = PH_LEAD;
      hcnt_d  = 8'd0;
      bit_d   = 3'd0;
      byte_d  = 5'd0;
    end
  end

  always_ff @(posedge _50MHz_CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_LEAD;
      hcnt_q    <= 8'd0;
      bit_q     <= 3'd0;
      byte_q    <= 5'd0;
      pending_q <= 1'b0;
      auto_q    <= '0;
      bright_q  <= 3'd0;
      disp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      hcnt_q    <= hcnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      pending_q <= pending_d;
      auto_q    <= auto_d;
      if (go) begin
        bright_q <= brightness;
        disp_q   <= disp_on;
      end
    end
  end

  always_ff @(posedge _50MHz_CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
    end else if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge _50MHz_CLK) begin
    if (load_byte) tx_byte_q <= tx_next;
  end

  // Link outputs decode registered state only, so reset idles them at once.
  assign seg_act    = (state_q == S_SEG1) || (state_q == S_SEG2) || (state_q == S_SEG3);
  assign busy       = seg_act || (state_q == S_GAP1) || (state_q == S_GAP2);
  assign frame_done = (state_q == S_DONE);
  assign stb        = ~seg_act;
  assign clk        = ~(seg_act && (phase_q == PH_LOW));
  assign dio        = (seg_act && (phase_q != PH_LEAD)) ? tx_byte_q[bit_q] : 1'b1;

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
module tb_tm1638_frame_sequencer;

  logic       sys_clk = 1'b0;
  logic       rst_n, rst_a_n, wr_en, disp_on, start;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] brightness;
  logic       busy, frame_done, sclk, stb, dio;
  logic       a_busy, a_fd, a_clk, a_stb, a_dio;

  int n_cmp = 0;
  int n_bad = 0;

  tm1638_frame_sequencer #(.CLK_DIV(2), .AUTO_PERIOD(0)) u_dut (
    ._50MHz_CLK(sys_clk), .RST(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .brightness(brightness), .disp_on(disp_on), .start(start),
    .busy(busy), .frame_done(frame_done), .clk(sclk), .stb(stb), .dio(dio)
  );

  tm1638_frame_sequencer #(.CLK_DIV(2), .AUTO_PERIOD(1000)) u_auto (
    ._50MHz_CLK(sys_clk), .RST(rst_a_n), .wr_en(1'b0), .wr_addr(4'd0),
    .wr_data(8'd0), .brightness(3'd0), .disp_on(1'b0), .start(1'b0),
    .busy(a_busy), .frame_done(a_fd), .clk(a_clk), .stb(a_stb), .dio(a_dio)
  );

  always #5 sys_clk = ~sys_clk;

  // Link monitor: decodes bytes on serial clk rising edges, measures gaps,
  // busy length and frame_done placement.
  int         cyc = 0;
  logic [7:0] rx_q[$];
  int         gap_q[$];
  logic [7:0] sh;
  int         nbits = 0, gcnt = 0, busy_run = 0, busy_len = 0;
  int         fd_cnt = 0, fd_orphan = 0, dio_glitch = 0;
  logic       p_clk = 1'b1, p_stb = 1'b1, p_dio = 1'b1, p_busy = 1'b0;

  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (stb) begin
      nbits <= 0;
    end else if (!p_clk && sclk) begin
      sh <= {dio, sh[7:1]};
      if (nbits == 7) begin
        rx_q.push_back({dio, sh[7:1]});
        nbits <= 0;
      end else begin
        nbits <= nbits + 1;
      end
    end
    if (busy && stb) gcnt <= gcnt + 1;
    else if (!stb && p_stb && gcnt > 0) begin
      gap_q.push_back(gcnt);
      gcnt <= 0;
    end else if (!busy) gcnt <= 0;
    if (busy) busy_run <= busy_run + 1;
    else begin
      if (p_busy) busy_len <= busy_run;
      busy_run <= 0;
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      if (!p_busy || busy) fd_orphan <= fd_orphan + 1;
    end
    if (!stb && !p_stb && p_clk && sclk && dio !== p_dio) dio_glitch <= dio_glitch + 1;
    p_clk  <= sclk;
    p_stb  <= stb;
    p_dio  <= dio;
    p_busy <= busy;
  end

  int   a_fd_cyc = -1;
  int   a_iv_q[$];
  int   a_idle_bad = 0;
  logic a_pbusy = 1'b0;

  always @(negedge sys_clk) begin
    a_pbusy <= a_busy;
    if (a_fd) a_fd_cyc <= cyc;
    if (a_busy && !a_pbusy && a_fd_cyc >= 0) a_iv_q.push_back(cyc - a_fd_cyc);
    if (rst_a_n && !a_busy && (a_clk !== 1'b1 || a_stb !== 1'b1 || a_dio !== 1'b1))
      a_idle_bad <= a_idle_bad + 1;
  end

  logic [7:0] mdl [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge sys_clk);
    #1 start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge sys_clk);
    #1 wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge sys_clk);
    #1 wr_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic wait_fd(input string tag, input int limit);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    n_cmp++;
    assert (frame_done === 1'b1) else begin
      n_bad++;
      $error("FAIL %s: observed no frame_done after %0d cycles, expected a pulse", tag, n);
    end
  endtask

  task automatic check_frame(input string tag, input int base, input logic [2:0] b, input logic d);
    logic [7:0] e [19];
    logic [7:0] got;
    e[0]  = 8'h40;
    e[1]  = 8'hC0;
    for (int j = 0; j < 16; j++) e[2+j] = mdl[j];
    e[18] = {1'b1, 3'b000, d, b};
    check({tag, "_nbytes"}, rx_q.size() - base, 19);
    for (int i = 0; i < 19; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base+i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, e[i]});
    end
  endtask

  initial begin
    int base, gbase, fdb;
    rst_n = 1'b1; rst_a_n = 1'b1;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
    brightness = 3'd0; disp_on = 1'b0; start = 1'b0;
    for (int j = 0; j < 16; j++) mdl[j] = 8'h00;
    #2 rst_n = 1'b0; rst_a_n = 1'b0;
    #10;
    check("rst_clk", sclk, 1);
    check("rst_stb", stb, 1);
    check("rst_dio", dio, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    @(posedge sys_clk);
    #1 rst_n = 1'b1; rst_a_n = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1 check("idle_no_auto", busy, 0);

    // Frame 1: all-zero RAM, default control
    base = rx_q.size(); gbase = gap_q.size(); fdb = fd_cnt;
    pulse_start();
    wait_fd("f1_wait", 2000);
    @(negedge sys_clk);
    check("f1_busy_len", busy_len, 628);
    check("f1_fd_count", fd_cnt - fdb, 1);
    check("f1_fd_after_busy", fd_orphan, 0);
    check_frame("f1", base, 3'd0, 1'b0);
    check("f1_gap1", (gap_q.size() > gbase) ? gap_q[gbase] : -1, 4);
    check("f1_gap2", (gap_q.size() > gbase + 1) ? gap_q[gbase+1] : -1, 4);

    // Frame 2: written bytes and full brightness
    wr(4'd0, 8'h3F);
    wr(4'd15, 8'h06);
    brightness = 3'd7; disp_on = 1'b1;
    base = rx_q.size(); gbase = gap_q.size();
    pulse_start();
    wait_fd("f2_wait", 2000);
    @(negedge sys_clk);
    check_frame("f2", base, 3'd7, 1'b1);
    check("f2_ngaps", gap_q.size() - gbase, 2);
    check("f2_gap1", (gap_q.size() > gbase) ? gap_q[gbase] : -1, 4);
    check("f2_gap2", (gap_q.size() > gbase + 1) ? gap_q[gbase+1] : -1, 4);
    check("f2_busy_len", busy_len, 628);

    // Pending: three requests during a frame collapse to one extra frame
    fdb = fd_cnt;
    pulse_start();
    repeat (98) @(posedge sys_clk);
    pulse_start();
    repeat (100) @(posedge sys_clk);
    pulse_start();
    repeat (100) @(posedge sys_clk);
    pulse_start();
    wait_fd("pend_wait1", 2000);
    @(negedge sys_clk);
    check("pend_chain_busy", busy, 1);
    check("pend_chain_fd", frame_done, 0);
    wait_fd("pend_wait2", 2000);
    repeat (30) @(negedge sys_clk);
    check("pend_idle_after", busy, 0);
    check("pend_fd_count", fd_cnt - fdb, 2);
    check("pend_busy_len", busy_len, 628);

    // Mid-frame writes: ram[5] before it is shifted, ram[3] after
    base = rx_q.size();
    pulse_start();
    repeat (210) @(posedge sys_clk);
    #1 wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hAA;
    @(posedge sys_clk);
    #1 wr_addr = 4'd3; wr_data = 8'h55;
    @(posedge sys_clk);
    #1 wr_en = 1'b0;
    mdl[5] = 8'hAA;
    wait_fd("mid_wait1", 2000);
    @(negedge sys_clk);
    check_frame("mid1", base, 3'd7, 1'b1);
    mdl[3] = 8'h55;
    base = rx_q.size();
    pulse_start();
    wait_fd("mid_wait2", 2000);
    @(negedge sys_clk);
    check_frame("mid2", base, 3'd7, 1'b1);

    // Asynchronous reset in the middle of SEG2 with a request pending
    pulse_start();
    repeat (100) @(posedge sys_clk);
    #1 start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    check("ar_pre_stb", stb, 0);
    #1 rst_n = 1'b0;
    #1;
    check("ar_clk", sclk, 1);
    check("ar_stb", stb, 1);
    check("ar_dio", dio, 1);
    check("ar_busy", busy, 0);
    @(posedge sys_clk);
    #1 rst_n = 1'b1;
    for (int j = 0; j < 16; j++) mdl[j] = 8'h00;
    repeat (40) @(negedge sys_clk);
    check("ar_stay_idle_busy", busy, 0);
    check("ar_stay_idle_stb", stb, 1);
    brightness = 3'd0; disp_on = 1'b0;
    base = rx_q.size();
    pulse_start();
    wait_fd("ar_wait", 2000);
    @(negedge sys_clk);
    check_frame("ar_frame", base, 3'd0, 1'b0);
    check("ar_busy_len", busy_len, 628);
    check("dio_only_on_clk_fall", dio_glitch, 0);

    // Auto refresh instance
    begin
      int n;
      n = 0;
      while (a_iv_q.size() < 2 && n < 6000) begin
        @(negedge sys_clk);
        n++;
      end
    end
    check("auto_intervals_seen", (a_iv_q.size() >= 2) ? 1 : 0, 1);
    check("auto_iv0", (a_iv_q.size() > 0) ? a_iv_q[0] : -1, 1001);
    check("auto_iv1", (a_iv_q.size() > 1) ? a_iv_q[1] : -1, 1001);
    check("auto_idle_levels", a_idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tm1638_frame_sequencer.md
Name: tm1638_frame_sequencer

Overview:
- Controller that sequences the 3-wire serial display link (clk/stb/dio) driven from the 50 MHz board clock.
- Holds a 16-byte display shadow RAM, written by upstream logic (e.g. the MOD60 counter/decoder).
- Periodically, or on request, emits one complete refresh frame: data command, address plus 16 data bytes, then display control.
- Output-only link; dio is never tristated and key scan is not supported.

Parameters:
- CLK_DIV, 25, half-period of serial clk in system cycles (H); legal range 2..255; default gives 1 MHz.
- AUTO_PERIOD, 500000, system cycles between automatic frame starts (10 ms); 0 disables auto refresh.

Ports:
- _50MHz_CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- wr_en  in  1  shadow RAM write strobe.
- wr_addr  in  4  shadow RAM byte address.
- wr_data  in  8  shadow RAM byte.
- brightness  in  3  display pulse width, 0..7.
- disp_on  in  1  display enable.
- start  in  1  one-cycle frame request.
- busy  out  1  high from the first stb-low cycle to the last cycle of the frame.
- frame_done  out  1  one-cycle pulse after the last stb rise of a frame.
- clk  out  1  serial clock, idles high.
- stb  out  1  serial strobe, active low.
- dio  out  1  serial data.

Behaviour:
- Reset (async, RST=0): clk=1, stb=1, dio=1, busy=0, frame_done=0, FSM=IDLE, pending=0, auto counter=0. Shadow RAM is cleared to 0x00.
- RAM write: on wr_en, ram[wr_addr]<=wr_data next edge. Writes are accepted in every state.
- A byte is sampled from RAM when its first bit's low phase begins. A write landing before that point is transmitted in the current frame; otherwise it goes out in the next frame.
- Frame start:
  - In IDLE, start=1 or auto counter reaching AUTO_PERIOD-1 starts a frame next cycle; the auto counter reloads to 0.
  - start or auto event while busy sets pending; the pending request starts one frame immediately after frame_done. Multiple requests collapse to one.
  - brightness/disp_on are latched at frame start.
- FSM: IDLE -> SEG1 -> GAP1 -> SEG2 -> GAP2 -> SEG3 -> DONE -> IDLE.
  - SEG1 sends 0x40 (write, auto-increment).
  - SEG2 sends 0xC0, then ram[0]..ram[15].
  - SEG3 sends 0x80 | disp_on<<3 | brightness.
  - DONE lasts 1 cycle and asserts frame_done.
- Segment timing for n bytes:
  - stb low for H cycles with clk=1.
  - Then per bit, LSB first: clk=0 with dio=bit for H cycles, then clk=1 for H cycles. dio changes only at the clk falling edge.
  - After the last bit, clk stays 1 and stb stays low for H more cycles, then stb=1.
  - stb low time = (16n+2)·H.
- Gaps: stb=1, clk=1 for 2H cycles.
- Between segments, and after the frame, dio=1.
- Frame length from the first stb-low cycle to the last stb-low cycle plus gaps = 18H+2H+274H+2H+18H = 314H cycles. busy is high for exactly 314H cycles; frame_done follows the next cycle.
- Auto counter runs only in IDLE and holds while busy.
- Counter widths: half-period counter 8 bits, bit counter 3 bits, byte counter 5 bits; no wrap beyond terminal counts.
- Reset mid-frame: link returns to idle levels asynchronously; no partial-frame completion; pending is cleared.

Test Plan:
- CLK_DIV=2, AUTO_PERIOD=0, reset then start pulse -> busy high 628 cycles, frame_done one pulse. Decoded bytes on clk rising edges: 0x40 | 0xC0, 16×0x00 | 0x80 (disp_on=0, bright=0).
- Write ram[0]=0x3F, ram[15]=0x06, brightness=7, disp_on=1, start -> SEG2 bytes 0xC0,0x3F,0x00..,0x06; SEG3 byte 0x8F; stb high between segments for 4 cycles.
- start asserted again at cycle 100 of a frame, then twice more -> exactly one extra frame begins the cycle after frame_done; pending then clear.
- Write ram[5]=0xAA before byte 5 starts shifting and ram[3]=0x55 after byte 3 finished -> frame shows ram[5]=0xAA and old ram[3]; next frame shows 0x55.
- AUTO_PERIOD=1000, CLK_DIV=2 -> frames start every 1000 IDLE cycles, i.e. 1000 idle cycles after each frame_done, with no start input.
- RST low mid-SEG2 -> clk, stb, dio = 1 and busy=0 within the same cycle, with no clock edge needed. After release, the link stays idle until start.
